// File: rtl/tl_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tl_phase_scheduler
//
// Request-driven phase scheduler for the three-way crossing (J, P, C).
// One direction at a time is given GREEN, then YELLOW, then ALLRED. After
// ALLRED the next direction is picked round-robin from the latched requests.
// If no request is latched, the scheduler falls back to the plain J->P->C
// rotation. A green phase lasts at least MIN_G s when it is ended by a
// competing request, and never more than MAX_G s. The manual advance ends
// a green phase at once.
//
// Parameters
//   UCY    clk cycles per 1 s tick (>= 2)
//   MIN_G  minimum green in seconds (1..MAX_G)
//   MAX_G  maximum green in seconds (<= 255)
//   Y      yellow in seconds (>= 1)
//   AR     all-red in seconds (>= 1)
//
// Ports
//   clk      in   1  system clock
//   rst      in   1  synchronous reset, active low
//   req      in   3  request pulses/levels, bit0=J bit1=P bit2=C
//   adv      in   1  manual advance, ends the current green
//   green    out  3  one-hot green lamp (same bit order as req)
//   yellow   out  3  one-hot yellow lamp
//   cur_dir  out  2  direction owning the phase, 0=J 1=P 2=C
//   phase    out  2  0=GREEN 1=YELLOW 2=ALLRED
//   tick     out  1  one-cycle pulse in the last cycle of each second
// -----------------------------------------------------------------------------
module tl_phase_scheduler #(
    parameter int UCY   = 1000,
    parameter int MIN_G = 3,
    parameter int MAX_G = 10,
    parameter int Y     = 3,
    parameter int AR    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       adv,
    output logic [2:0] green,
    output logic [2:0] yellow,
    output logic [1:0] cur_dir,
    output logic [1:0] phase,
    output logic       tick
);

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2
    } phase_e;

    localparam int          PW       = (UCY > 2) ? $clog2(UCY) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(UCY - 1);
    localparam logic [31:0] MIN_G_L  = 32'(MIN_G);
    localparam logic [31:0] MAX_G_L  = 32'(MAX_G);
    localparam logic [31:0] Y_L      = 32'(Y);
    localparam logic [31:0] AR_L     = 32'(AR);

    // One-hot lamp/request pattern for a direction code; code 3 maps to none.
    function automatic logic [2:0] onehot_f(input logic [1:0] d);
        logic [2:0] oh;
        case (d)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Successor of a direction in the J->P->C rotation.
    function automatic logic [1:0] succ_f(input logic [1:0] d);
        logic [1:0] s;
        case (d)
            2'd0:    s = 2'd1;
            2'd1:    s = 2'd2;
            default: s = 2'd0;
        endcase
        return s;
    endfunction

    // Round-robin pick: first pending direction after d, otherwise d+1.
    function automatic logic [1:0] pick_f(input logic [1:0] d, input logic [2:0] pend);
        logic [1:0] c1;
        logic [1:0] c2;
        logic [1:0] nd;
        c1 = succ_f(d);
        c2 = succ_f(c1);
        if ((pend & onehot_f(c1)) != 3'b000) begin
            nd = c1;
        end else if ((pend & onehot_f(c2)) != 3'b000) begin
            nd = c2;
        end else begin
            nd = c1;
        end
        return nd;
    endfunction

    phase_e        phase_r;
    logic [1:0]    dir_r;
    logic [PW-1:0] pre_r;
    logic [7:0]    sc_r;
    logic [2:0]    pending_r;

    logic [2:0]    req_mask_s;
    logic [2:0]    pend_eff_s;
    logic [31:0]   sc_inc_s;
    logic          green_exit_s;
    logic          yellow_exit_s;
    logic          allred_exit_s;
    logic          phase_chg_s;
    logic [1:0]    next_dir_s;
    logic [PW-1:0] pre_next_s;
    logic [7:0]    sc_next_s;
    logic [2:0]    pending_next_s;

    // Request latching: the green direction's own request is dropped.
    always_comb begin
        req_mask_s = 3'b111;
        if (phase_r == PH_GREEN) begin
            req_mask_s = ~onehot_f(dir_r);
        end else begin
            req_mask_s = 3'b111;
        end
        pend_eff_s = pending_r | (req & req_mask_s);
        next_dir_s = pick_f(dir_r, pend_eff_s);
    end

    // Phase exit conditions; seconds elapsed counts the tick in progress.
    always_comb begin
        sc_inc_s      = 32'(sc_r) + 32'd1;
        green_exit_s  = 1'b0;
        yellow_exit_s = 1'b0;
        allred_exit_s = 1'b0;
        phase_chg_s   = 1'b0;
        if (adv) begin
            green_exit_s = 1'b1;
        end else if (tick && (sc_inc_s >= MAX_G_L)) begin
            green_exit_s = 1'b1;
        end else if (tick && (sc_inc_s >= MIN_G_L)
                     && ((pending_r & ~onehot_f(dir_r)) != 3'b000)) begin
            green_exit_s = 1'b1;
        end else begin
            green_exit_s = 1'b0;
        end
        yellow_exit_s = tick && (sc_inc_s >= Y_L);
        allred_exit_s = tick && (sc_inc_s >= AR_L);
        case (phase_r)
            PH_GREEN:  phase_chg_s = green_exit_s;
            PH_YELLOW: phase_chg_s = yellow_exit_s;
            PH_ALLRED: phase_chg_s = allred_exit_s;
            default:   phase_chg_s = 1'b1;
        endcase
    end

    // Prescaler, second counter and pending latch next values.
    always_comb begin
        pre_next_s     = pre_r;
        sc_next_s      = sc_r;
        pending_next_s = pend_eff_s;
        if (phase_chg_s) begin
            pre_next_s = '0;
            sc_next_s  = 8'd0;
        end else if (pre_r == PRE_LAST) begin
            pre_next_s = '0;
            sc_next_s  = sc_r + 8'd1;
        end else begin
            pre_next_s = pre_r + PW'(1);
            sc_next_s  = sc_r;
        end
        // A grant clears the winner's request, including one arriving now.
        if (phase_chg_s && (phase_r == PH_ALLRED)) begin
            pending_next_s = pend_eff_s & ~onehot_f(next_dir_s);
        end else begin
            pending_next_s = pend_eff_s;
        end
    end

    // Phase FSM with registered lamp, tick and counter state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_r   <= PH_GREEN;
            dir_r     <= 2'd0;
            pre_r     <= '0;
            sc_r      <= 8'd0;
            pending_r <= 3'b000;
            green     <= 3'b001;
            yellow    <= 3'b000;
            tick      <= 1'b0;
        end else begin
            pre_r     <= pre_next_s;
            sc_r      <= sc_next_s;
            pending_r <= pending_next_s;
            tick      <= (pre_next_s == PRE_LAST);
            case (phase_r)
                PH_GREEN: begin
                    if (green_exit_s) begin
                        phase_r <= PH_YELLOW;
                        green   <= 3'b000;
                        yellow  <= onehot_f(dir_r);
                    end else begin
                        green   <= onehot_f(dir_r);
                        yellow  <= 3'b000;
                    end
                end
                PH_YELLOW: begin
                    if (yellow_exit_s) begin
                        phase_r <= PH_ALLRED;
                        green   <= 3'b000;
                        yellow  <= 3'b000;
                    end else begin
                        green   <= 3'b000;
                        yellow  <= onehot_f(dir_r);
                    end
                end
                PH_ALLRED: begin
                    if (allred_exit_s) begin
                        phase_r <= PH_GREEN;
                        dir_r   <= next_dir_s;
                        green   <= onehot_f(next_dir_s);
                        yellow  <= 3'b000;
                    end else begin
                        green   <= 3'b000;
                        yellow  <= 3'b000;
                    end
                end
                default: begin
                    // Illegal encoding: fall back to a safe J green.
                    phase_r <= PH_GREEN;
                    dir_r   <= 2'd0;
                    green   <= 3'b001;
                    yellow  <= 3'b000;
                end
            endcase
        end
    end

    assign phase   = phase_r;
    assign cur_dir = dir_r;

endmodule
